// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM state
// encodings and the latched request record.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: store byte enables and data shift,
// load lane select with sign or zero extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be       = 4'b0000;
    rdata    = '0;
    wdata_sh = wdata << {addr_lo, 3'b000};
    rbyte    = rword[{addr_lo, 3'b000} +: 8];
    rhalf    = rword[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        rdata = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        be    = 4'b0011 << addr_lo;
        rdata = {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        be    = 4'b1111;
        rdata = rword;
      end
      F3_BU:   rdata = {24'b0, rbyte};
      F3_HU:   rdata = {16'b0, rhalf};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with WAIT_STATES cycles of latency.
// Define DMEM_MMIO_EN to map a free-running cycle counter at word address MMIO_BASE.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_M1   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  dmem_req_t     req_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [31:0]   wdata_sh;
  logic [31:0]   lane_rdata;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic          f3_bad;
  logic          misalign;
  logic          is_mmio;
  logic          out_range;
  logic          mmio_err;
  logic          acc_err;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle strobe with no ready.
  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;
  assign widx      = req_q.addr[AW+1:2];
  assign rword     = mem[widx];

  dmem_lane_align u_lane (
    .funct3   (req_q.funct3),
    .addr_lo  (req_q.addr[1:0]),
    .wdata    (req_q.wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (lane_rdata)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign load_data = is_mmio ? cyc_cnt : lane_rdata;
  assign mmio_err  = is_mmio && (req_q.funct3 != F3_W);
`else
  assign load_data = lane_rdata;
  assign mmio_err  = is_mmio;
`endif

  always_comb begin
    f3_bad    = (req_q.funct3[1:0] == 2'b11) || (req_q.funct3 == 3'b110) ||
                (req_q.we && req_q.funct3[2]);
    misalign  = ((req_q.funct3[1:0] == 2'b01) && req_q.addr[0]) ||
                ((req_q.funct3[1:0] == 2'b10) && (req_q.addr[1:0] != 2'b00));
    is_mmio   = (req_q.addr[31:2] == MMIO_BASE[29:0]);
    out_range = !is_mmio && ({2'b00, req_q.addr[31:2]} >= DEPTH_W);
    acc_err   = f3_bad || misalign || out_range || mmio_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WS_M1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= acc_err;
          rsp_rdata <= (acc_err || req_q.we) ? 32'd0 : load_data;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset; a reset during WAIT leaves state in IDLE so no write occurs.
  always_ff @(posedge clk) begin
    if (state == ST_RESP && req_q.we && !acc_err && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
